// File: rtl/perf_snapshot_ctrl_pkg.sv
// perf_snapshot_ctrl_pkg: shared word type, register offsets, CTRL/STATUS bits and FSM states.
// Revision 1.0
`default_nettype none

package perf_snapshot_ctrl_pkg;

  typedef logic [15:0] lc3b_word;

  // Word offsets inside the 64-byte MMIO window
  localparam logic [4:0] PERF_CTRL_OFS = 5'd0;
  localparam logic [4:0] PERF_STAT_OFS = 5'd1;
  localparam logic [4:0] PERF_SNAP_OFS = 5'd2;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_CLEAR_BIT = 1;
  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_VALID_BIT = 1;

  typedef enum logic [1:0] {
    PS_IDLE  = 2'd0,
    PS_SCAN  = 2'd1,
    PS_CLEAR = 2'd2,
    PS_DONE  = 2'd3
  } perf_snap_state_t;

endpackage

`default_nettype wire

// File: rtl/perf_snapshot_ctrl_if.sv
// perf_snapshot_ctrl_if: lc3b-style MMIO read/write/resp bus between the MEM stage and the controller.
// Revision 1.0
`default_nettype none

interface perf_snapshot_ctrl_if;
  import perf_snapshot_ctrl_pkg::*;

  logic [15:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  lc3b_word    mem_wdata;
  lc3b_word    mem_rdata;
  logic        mem_resp;

  modport master (
    output mem_address, mem_read, mem_write, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_wdata,
    output mem_rdata, mem_resp
  );

endinterface

`default_nettype wire

// File: rtl/perf_snapshot_ctrl_mmio_slave.sv
// perf_snapshot_ctrl_mmio_slave: window decode, one-resp-per-request guard, registered resp/rdata, read mux.
// Revision 1.0
`default_nettype none

module perf_snapshot_ctrl_mmio_slave
  import perf_snapshot_ctrl_pkg::*;
#(
  parameter int          NUM_CTRS  = 12,
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int          SEL_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  perf_snapshot_ctrl_if.slave   bus,
  input  logic                  busy_i,
  input  logic                  valid_i,
  input  lc3b_word              snap_i [NUM_CTRS],
  output logic                  ctrl_start_o,
  output logic                  ctrl_clear_o
);

  logic       guard_q;
  logic       resp_q;
  lc3b_word   rdata_q;

  logic       in_window;
  logic       req;
  logic       is_snap;
  logic       snap_stall;
  logic       accept;
  logic [4:0] ofs;
  logic [4:0] snap_ofs;
  lc3b_word   rmux;

  logic        unused_addr_lsb;
  logic [13:0] unused_wdata_hi;
  assign unused_addr_lsb = bus.mem_address[0];
  assign unused_wdata_hi = bus.mem_wdata[15:2];

  assign ofs        = bus.mem_address[5:1];
  assign in_window  = (bus.mem_address[15:6] == BASE_ADDR[15:6]);
  assign req        = bus.mem_read | bus.mem_write;
  assign snap_ofs   = ofs - PERF_SNAP_OFS;
  assign is_snap    = (ofs >= PERF_SNAP_OFS) && (snap_ofs < 5'(NUM_CTRS));
  // Snapshot reads wait for the scan to finish so they never return a half-updated buffer
  assign snap_stall = is_snap && !bus.mem_write && busy_i;
  assign accept     = req && in_window && !guard_q && !snap_stall;

  assign ctrl_start_o = accept && bus.mem_write && (ofs == PERF_CTRL_OFS)
                        && bus.mem_wdata[CTRL_START_BIT];
  assign ctrl_clear_o = bus.mem_wdata[CTRL_CLEAR_BIT];

  always_comb begin
    rmux = '0;
    if (ofs == PERF_STAT_OFS) begin
      rmux[STAT_BUSY_BIT]  = busy_i;
      rmux[STAT_VALID_BIT] = valid_i;
    end else if (is_snap) begin
      rmux = snap_i[snap_ofs[SEL_W-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      guard_q <= 1'b0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      resp_q  <= accept;
      rdata_q <= (accept && !bus.mem_write) ? rmux : '0;
      if (accept) begin
        guard_q <= 1'b1;
      end else if (!req) begin
        guard_q <= 1'b0;
      end
    end
  end

  assign bus.mem_resp  = resp_q;
  assign bus.mem_rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/perf_snapshot_ctrl.sv
// perf_snapshot_ctrl: scans the counter bank into a snapshot buffer, optionally clears it, serves it over MMIO.
// Revision 1.0
`default_nettype none

module perf_snapshot_ctrl
  import perf_snapshot_ctrl_pkg::*;
#(
  parameter int          NUM_CTRS  = 12,
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int          SEL_W     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  perf_snapshot_ctrl_if.slave mem,
  output logic [SEL_W-1:0]    ctr_sel,
  output logic                ctr_clear,
  input  logic [15:0]         ctr_value,
  output logic                busy
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_CTRS - 1);

  perf_snap_state_t state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             clr_mode_q, clr_mode_d;
  lc3b_word         snap_q [NUM_CTRS];
  lc3b_word         snap_d [NUM_CTRS];

  logic ctrl_start;
  logic ctrl_clear;

  perf_snapshot_ctrl_mmio_slave #(
    .NUM_CTRS  (NUM_CTRS),
    .BASE_ADDR (BASE_ADDR),
    .SEL_W     (SEL_W)
  ) u_mmio (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (mem),
    .busy_i       (busy),
    .valid_i      (valid_q),
    .snap_i       (snap_q),
    .ctrl_start_o (ctrl_start),
    .ctrl_clear_o (ctrl_clear)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PS_IDLE;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      clr_mode_q <= 1'b0;
      for (int i = 0; i < NUM_CTRS; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      clr_mode_q <= clr_mode_d;
      for (int i = 0; i < NUM_CTRS; i++) begin
        snap_q[i] <= snap_d[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    valid_d    = valid_q;
    clr_mode_d = clr_mode_q;
    snap_d     = snap_q;
    ctr_sel    = '0;
    ctr_clear  = 1'b0;

    unique case (state_q)
      PS_IDLE: begin
        // Start requests while busy never reach here, so a running scan cannot restart
        if (ctrl_start) begin
          clr_mode_d = ctrl_clear;
          idx_d      = '0;
          valid_d    = 1'b0;
          state_d    = PS_SCAN;
        end
      end
      PS_SCAN: begin
        ctr_sel       = idx_q;
        snap_d[idx_q] = ctr_value;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = clr_mode_q ? PS_CLEAR : PS_DONE;
        end else begin
          idx_d = idx_q + SEL_W'(1);
        end
      end
      PS_CLEAR: begin
        ctr_sel   = idx_q;
        ctr_clear = 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = PS_DONE;
        end else begin
          idx_d = idx_q + SEL_W'(1);
        end
      end
      PS_DONE: begin
        valid_d = 1'b1;
        state_d = PS_IDLE;
      end
      default: state_d = PS_IDLE;
    endcase
  end

  assign busy = (state_q != PS_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_perf_snapshot_ctrl.sv
// tb_perf_snapshot_ctrl: directed self-checking bench with a behavioural counter bank.
// Revision 1.0
`default_nettype none

module tb_perf_snapshot_ctrl;

  localparam logic [15:0] BASE = 16'hFF00;
  localparam logic [15:0] A_CTRL = BASE;
  localparam logic [15:0] A_STAT = BASE + 16'd2;

  logic        clk;
  logic        rst_n;
  logic [3:0]  ctr_sel;
  logic        ctr_clear;
  logic [15:0] ctr_value;
  logic        busy;

  perf_snapshot_ctrl_if mif ();

  perf_snapshot_ctrl #(
    .NUM_CTRS  (12),
    .BASE_ADDR (BASE),
    .SEL_W     (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem       (mif),
    .ctr_sel   (ctr_sel),
    .ctr_clear (ctr_clear),
    .ctr_value (ctr_value),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter bank model
  logic [15:0] ctrs    [16];
  int          clr_cnt [16];
  logic        load_en;
  logic [15:0] load_base;

  assign ctr_value = ctrs[ctr_sel];

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 16; i++) begin
        ctrs[i]    <= load_base + 16'(i);
        clr_cnt[i] <= 0;
      end
    end else if (ctr_clear) begin
      ctrs[ctr_sel]    <= 16'h0000;
      clr_cnt[ctr_sel] <= clr_cnt[ctr_sel] + 1;
    end
  end

  // Busy-cycle monitor
  int         mon_n = 0;
  logic [4:0] seq   [256];

  always @(negedge clk) begin
    if (busy) begin
      seq[mon_n[7:0]] <= {ctr_clear, ctr_sel};
      mon_n           <= mon_n + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_bank(input logic [15:0] b);
    load_base = b;
    load_en   = 1'b1;
    @(posedge clk); #1;
    load_en   = 1'b0;
  endtask

  // Issue one request, wait up to 'bound' cycles for resp, then release the bus for one idle cycle
  task automatic bus_xfer(input logic is_wr, input logic [15:0] addr, input logic [15:0] wdata,
                          input int bound, output logic [15:0] rdata, output logic got,
                          output int lat, output logic busy_at_resp);
    mif.mem_address = addr;
    mif.mem_write   = is_wr;
    mif.mem_read    = !is_wr;
    mif.mem_wdata   = wdata;
    got = 1'b0; lat = 0; rdata = '0; busy_at_resp = 1'b0;
    while (!got && lat < bound) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (mif.mem_resp) begin
        got          = 1'b1;
        rdata        = mif.mem_rdata;
        busy_at_resp = busy;
      end
    end
    @(posedge clk); #1;
    mif.mem_read  = 1'b0;
    mif.mem_write = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic        got, bar;
    int          lat, base, cnt;
    logic        found;

    rst_n = 1'b0;
    load_en = 1'b0;
    load_base = '0;
    mif.mem_address = '0;
    mif.mem_read = 1'b0;
    mif.mem_write = 1'b0;
    mif.mem_wdata = '0;

    repeat (2) @(posedge clk);
    #1;
    load_bank(16'h0010);
    @(negedge clk);
    check("rst_resp",  32'(mif.mem_resp),  32'd0);
    check("rst_rdata", 32'(mif.mem_rdata), 32'd0);
    check("rst_sel",   32'(ctr_sel),       32'd0);
    check("rst_clear", 32'(ctr_clear),     32'd0);
    check("rst_busy",  32'(busy),          32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    bus_xfer(1'b0, A_STAT, 16'h0, 5, rd, got, lat, bar);
    check("rst_status", 32'(rd), 32'h0000);

    // CTRL write without start bit is a no-op
    bus_xfer(1'b1, A_CTRL, 16'h0002, 5, rd, got, lat, bar);
    check("noop_resp", 32'(got), 32'd1);
    check("noop_busy", 32'(busy), 32'd0);

    // Plain snapshot
    base = mon_n;
    bus_xfer(1'b1, A_CTRL, 16'h0001, 5, rd, got, lat, bar);
    check("start_lat", 32'(lat), 32'd1);
    wait_idle("scan_idle");
    check("scan_busy_cycles", 32'(mon_n - base), 32'd13);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("scan_sel%0d", i), 32'(seq[8'(base + i)]), 32'(i));
    end
    check("scan_done_sel", 32'(seq[8'(base + 12)]), 32'd0);
    for (int i = 0; i < 12; i++) begin
      bus_xfer(1'b0, BASE + 16'(2 * (2 + i)), 16'h0, 5, rd, got, lat, bar);
      check($sformatf("snap%0d", i), 32'(rd), 32'h0010 + 32'(i));
    end
    bus_xfer(1'b0, A_STAT, 16'h0, 5, rd, got, lat, bar);
    check("status_valid", 32'(rd), 32'h0002);

    // SNAP read during SCAN stalls until idle and returns the new capture
    load_bank(16'h0100);
    bus_xfer(1'b1, A_CTRL, 16'h0001, 5, rd, got, lat, bar);
    bus_xfer(1'b0, BASE + 16'd10, 16'h0, 40, rd, got, lat, bar);
    check("stall_got",  32'(got), 32'd1);
    check("stall_lat",  32'(lat), 32'd12);
    check("stall_busy", 32'(bar), 32'd0);
    check("stall_data", 32'(rd),  32'h0103);

    // STATUS read during SCAN is never stalled
    bus_xfer(1'b1, A_CTRL, 16'h0001, 5, rd, got, lat, bar);
    bus_xfer(1'b0, A_STAT, 16'h0, 5, rd, got, lat, bar);
    check("stat_scan_lat",  32'(lat), 32'd1);
    check("stat_scan_data", 32'(rd),  32'h0001);
    wait_idle("stat_scan_idle");

    // Snapshot + clear, with a second start landing in CLEAR
    load_bank(16'h0200);
    base = mon_n;
    bus_xfer(1'b1, A_CTRL, 16'h0003, 5, rd, got, lat, bar);
    repeat (12) @(posedge clk);
    #1;
    check("restart_in_clear", 32'(ctr_clear), 32'd1);
    bus_xfer(1'b1, A_CTRL, 16'h0003, 5, rd, got, lat, bar);
    check("restart_lat", 32'(lat), 32'd1);
    wait_idle("clr_idle");
    check("clr_busy_cycles", 32'(mon_n - base), 32'd25);
    for (int i = 0; i < 25; i++) begin
      logic [4:0] e;
      if (i < 12)      e = {1'b0, 4'(i)};
      else if (i < 24) e = {1'b1, 4'(i - 12)};
      else             e = 5'd0;
      check($sformatf("clr_seq%0d", i), 32'(seq[8'(base + i)]), 32'(e));
    end
    for (int i = 0; i < 12; i++) begin
      check($sformatf("clr_cnt%0d", i), 32'(clr_cnt[i]), 32'd1);
    end
    check("ctr_cleared", 32'(ctrs[7]), 32'd0);
    bus_xfer(1'b0, BASE + 16'd4, 16'h0, 5, rd, got, lat, bar);
    check("clr_snap0", 32'(rd), 32'h0200);
    bus_xfer(1'b0, BASE + 16'd26, 16'h0, 5, rd, got, lat, bar);
    check("clr_snap11", 32'(rd), 32'h020B);

    // Reset mid-CLEAR at idx 5
    load_bank(16'h0300);
    bus_xfer(1'b1, A_CTRL, 16'h0003, 5, rd, got, lat, bar);
    found = 1'b0;
    cnt   = 0;
    while (!found && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (ctr_clear && ctr_sel == 4'd5) found = 1'b1;
    end
    check("reach_clear5", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_clear", 32'(ctr_clear), 32'd0);
    check("arst_busy",  32'(busy),      32'd0);
    check("arst_sel",   32'(ctr_sel),   32'd0);
    @(posedge clk); #1;
    check("arst_cnt4",  32'(clr_cnt[4]), 32'd1);
    check("arst_cnt5",  32'(clr_cnt[5]), 32'd0);
    check("arst_ctr5",  32'(ctrs[5]),    32'h0305);
    check("arst_ctr11", 32'(ctrs[11]),   32'h030B);
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus_xfer(1'b0, A_STAT, 16'h0, 5, rd, got, lat, bar);
    check("arst_status", 32'(rd), 32'h0000);
    bus_xfer(1'b0, BASE + 16'd4, 16'h0, 5, rd, got, lat, bar);
    check("arst_snap0", 32'(rd), 32'h0000);

    // Window edges
    bus_xfer(1'b0, BASE + 16'h0040, 16'h0, 4, rd, got, lat, bar);
    check("outside_noresp", 32'(got), 32'd0);
    bus_xfer(1'b0, BASE + 16'd40, 16'h0, 5, rd, got, lat, bar);
    check("unused_resp", 32'(got), 32'd1);
    check("unused_data", 32'(rd),  32'h0000);

    // Request held for several cycles yields a single resp
    mif.mem_address = A_STAT;
    mif.mem_read    = 1'b1;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (mif.mem_resp) cnt++;
    end
    @(posedge clk); #1;
    mif.mem_read = 1'b0;
    check("held_one_resp", 32'(cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
